// File: rtl/alu_mc.sv
// Multi-cycle handshaked execute ALU: registered results, shift-add MUL/MULHU, optional restoring DIVU/REMU.
// Optional divider is built only when the ALU_DIV_EN macro is defined; otherwise opcodes A/B act as reserved.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t               state_q, state_d;
    logic                 sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flags_q, flags_d;

    logic                 accept, is_mul, is_div, last_step;
    logic [WIDTH-1:0]     add_b, simple_res, fin_res;
    logic [WIDTH:0]       add_sum;
    logic [1:0]           simple_cv;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH:0]       div_sh, div_diff;
    logic [2*WIDTH-1:0]   div_next;
`endif

    function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid  = (state_q == S_DONE);
`ifdef ALU_DIV_EN
    assign busy       = (state_q == S_MUL) | (state_q == S_DIV);
`else
    assign busy       = (state_q == S_MUL);
`endif
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign out_tag    = tag_q;

    assign accept    = in_valid & in_ready;
    assign is_mul    = (in_op[3:1] == 3'b100);
`ifdef ALU_DIV_EN
    assign is_div    = (in_op[3:1] == 3'b101);
`else
    assign is_div    = 1'b0;
`endif
    assign last_step = (cnt_q == SHAMT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        sel_hi_d = sel_hi_q;
        a_d      = a_q;
        tag_d    = tag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        fin_res  = '0;
`ifdef ALU_DIV_EN
        b_d      = b_q;
`endif

        // DIF reuses the adder as a + ~b + 1, so C means "no borrow"
        add_b      = in_op[0] ? ~in_b : in_b;
        add_sum    = {1'b0, in_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, in_op[0]};
        shamt      = in_b[SHAMT_W-1:0];
        simple_res = '0;
        simple_cv  = 2'b00;
        case (in_op)
            4'h0, 4'h1: begin
                simple_res = add_sum[WIDTH-1:0];
                simple_cv  = {add_sum[WIDTH],
                              ~(in_op[0] ^ in_a[WIDTH-1] ^ in_b[WIDTH-1]) &
                              (in_a[WIDTH-1] ^ add_sum[WIDTH-1])};
            end
            4'h2: simple_res = in_a & in_b;
            4'h3: simple_res = in_a | in_b;
            4'h4: simple_res = in_a ^ in_b;
            4'h5: simple_res = in_a << shamt;
            4'h6: simple_res = in_a >> shamt;
            4'h7: simple_res = $signed(in_a) >>> shamt;
            default: simple_res = '0;
        endcase

        // Multiplier bits consumed LSB-first from acc low half; partial product grows in the high half
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

        case (state_q)
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    fin_res  = sel_hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                    result_d = fin_res;
                    flags_d  = nz_flags(fin_res);
                    state_d  = S_DONE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    fin_res  = sel_hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                    result_d = fin_res;
                    flags_d  = nz_flags(fin_res);
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            sel_hi_d = in_op[0];
            a_d      = in_a;
            tag_d    = in_tag;
            cnt_d    = '0;
`ifdef ALU_DIV_EN
            b_d      = in_b;
`endif
            if (is_mul) begin
                acc_d   = {{WIDTH{1'b0}}, in_b};
                state_d = S_MUL;
            end else if (is_div) begin
`ifdef ALU_DIV_EN
                acc_d   = {{WIDTH{1'b0}}, in_a};
                state_d = S_DIV;
`endif
            end else begin
                result_d = simple_res;
                flags_d  = {nz_flags(simple_res)[3:2], simple_cv};
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_hi_q <= 1'b0;
            a_q      <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_DIV_EN
            b_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_hi_q <= sel_hi_d;
            a_q      <= a_d;
            tag_q    <= tag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_DIV_EN
            b_q      <= b_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32, TAG_W=4): directed spec vectors, random ops against a
// plain-arithmetic reference model, handshake/back-pressure, back-to-back and reset-mid-MUL scenarios.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_tag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .busy(busy)
    );

    // Reference: {result, N, Z, C, V}
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, v;
        logic [63:0] p;
        int          sh;
        r = '0; c = 1'b0; v = 1'b0;
        p = 64'(a) * 64'(b);
        sh = int'(b % 32);
        case (op)
            4'h0: begin r = a + b; c = (r < a); v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h1: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << sh;
            4'h6: r = a >> sh;
            4'h7: r = 32'($signed(a) >>> sh);
            4'h8: r = p[31:0];
            4'h9: r = p[63:32];
`ifdef ALU_DIV_EN
            4'hA: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hB: r = (b == 0) ? a : a % b;
`endif
            default: r = '0;
        endcase
        return {r, r[31], (r == 0), c, v};
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (op == 4'h8 || op == 4'h9) return 33;
`ifdef ALU_DIV_EN
        if (op == 4'hA || op == 4'hB) return 33;
`endif
        return 1;
    endfunction

    // Present one request for exactly one edge, then scramble inputs to prove they were latched
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 4'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) cyc = -1000;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b res=%h flags=%b tag=%h required 0 0 0 0 0",
                     out_valid, busy, out_result, out_flags, out_tag);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        int   cyc;
        logic [3:0] tag;
        v.push_back('{4'h1, 32'd5,          32'd7,  32'hFFFF_FFFE, 4'b1000, 1});
        v.push_back('{4'h0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000, 4'b1001, 1});
        v.push_back('{4'h0, 32'hFFFF_FFFF,  32'd1,  32'h0000_0000, 4'b0110, 1});
        v.push_back('{4'h7, 32'h8000_0000,  32'h24, 32'hF800_0000, 4'b1000, 1});
        v.push_back('{4'h6, 32'h8000_0000,  32'h24, 32'h0800_0000, 4'b0000, 1});
        v.push_back('{4'h8, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 33});
        v.push_back('{4'h9, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 33});
        v.push_back('{4'hC, 32'h1234_5678,  32'h9,  32'h0000_0000, 4'b0100, 1});
`ifdef ALU_DIV_EN
        v.push_back('{4'hA, 32'd100,        32'd7,  32'd14,        4'b0000, 33});
        v.push_back('{4'hB, 32'd100,        32'd7,  32'd2,         4'b0000, 33});
        v.push_back('{4'hA, 32'd9,          32'd0,  32'hFFFF_FFFF, 4'b1000, 33});
        v.push_back('{4'hB, 32'd9,          32'd0,  32'd9,         4'b0000, 33});
`else
        v.push_back('{4'hA, 32'd100,        32'd7,  32'd0,         4'b0100, 1});
        v.push_back('{4'hB, 32'd100,        32'd7,  32'd0,         4'b0100, 1});
`endif
        foreach (v[i]) begin
            tag = 4'(i + 3);
            send(v[i].op, v[i].a, v[i].b, tag);
            wait_valid(cyc);
            checks++;
            if (cyc + 1 !== v[i].lat) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, cyc + 1, v[i].lat);
            end
            checks++;
            if (out_result !== v[i].res) begin
                errors++;
                $display("FAIL dir%0d_result: got %h required %h", i, out_result, v[i].res);
            end
            checks++;
            if (out_flags !== v[i].fl) begin
                errors++;
                $display("FAIL dir%0d_flags: got %b required %b", i, out_flags, v[i].fl);
            end
            checks++;
            if (out_tag !== tag) begin
                errors++;
                $display("FAIL dir%0d_tag: got %h required %h", i, out_tag, tag);
            end
            take();
        end
    endtask

    task automatic test_mul_timing();
        int busy_cyc = 0;
        int bad = 0;
        send(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h7);
        while (!out_valid && busy_cyc < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            busy_cyc++;
        end
        checks++;
        if (bad != 0 || busy_cyc != 32) begin
            errors++;
            $display("FAIL mul_busy_window: busy cycles=%0d bad=%0d required 32 0", busy_cyc, bad);
        end
        checks++;
        if (out_result !== 32'h1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_done: res=%h busy=%b required 00000001 0", out_result, busy);
        end
        take();
    endtask

    task automatic test_random();
        logic [3:0]  op, tag;
        logic [31:0] a, b;
        logic [35:0] exp;
        int cyc;
        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            tag = 4'($urandom);
            exp = model(op, a, b);
            send(op, a, b, tag);
            wait_valid(cyc);
            checks++;
            if (cyc + 1 !== model_lat(op)) begin
                errors++;
                $display("FAIL rnd%0d_latency op=%h: got %0d required %0d", n, op, cyc + 1, model_lat(op));
            end
            checks++;
            if ({out_result, out_flags} !== exp) begin
                errors++;
                $display("FAIL rnd%0d op=%h a=%h b=%h: got %h/%b required %h/%b",
                         n, op, a, b, out_result, out_flags, exp[35:4], exp[3:0]);
            end
            checks++;
            if (out_tag !== tag) begin
                errors++;
                $display("FAIL rnd%0d_tag: got %h required %h", n, out_tag, tag);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        send(4'h0, 32'h7FFF_FFFF, 32'h1, 4'h5);
        wait_valid(cyc);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_op = 4'h4; in_a = $urandom; in_b = $urandom; in_tag = 4'hA;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h8000_0000 ||
                out_flags !== 4'b1001 || out_tag !== 4'h5) begin
                errors++;
                $display("FAIL hold%0d: rdy=%b vld=%b res=%h fl=%b tag=%h required 0 1 80000000 1001 5",
                         k, in_ready, out_valid, out_result, out_flags, out_tag);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_not_queued: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] a2, b2;
        a2 = $urandom; b2 = $urandom;
        send(4'h2, $urandom, $urandom, 4'h1);
        wait_valid(cyc);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'h4; in_a = a2; in_b = b2; in_tag = 4'h2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || {out_result, out_flags} !== model(4'h4, a2, b2) || out_tag !== 4'h2) begin
            errors++;
            $display("FAIL b2b_simple: vld=%b res=%h tag=%h required 1 %h 2",
                     out_valid, out_result, out_tag, a2 ^ b2);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'h9; in_a = a2; in_b = b2; in_tag = 4'h3;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_mul_start: busy=%b vld=%b required 1 0", busy, out_valid);
        end
        // A request during busy must be dropped
        in_valid = 1'b1; in_op = 4'h0; in_tag = 4'hF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if ({out_result, out_flags} !== model(4'h9, a2, b2) || out_tag !== 4'h3) begin
            errors++;
            $display("FAIL b2b_mulhu: res=%h tag=%h required %h 3", out_result, out_tag, model(4'h9, a2, b2) >> 4);
        end
        take();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_req_ignored: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int cyc;
        send(4'h8, 32'h0001_0003, 32'h0000_0005, 4'h9);
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: got %b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'h0 || out_flags !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: vld=%b busy=%b res=%h tag=%h fl=%b required 0 0 0 0 0",
                     out_valid, busy, out_result, out_tag, out_flags);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        send(4'h1, 32'd10, 32'd3, 4'h6);
        wait_valid(cyc);
        checks++;
        if (out_result !== 32'd7 || out_flags !== 4'b0010 || out_tag !== 4'h6) begin
            errors++;
            $display("FAIL rst_mid_after: res=%h fl=%b tag=%h required 00000007 0010 6", out_result, out_flags, out_tag);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_timing();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
